// File: rtl/core_ins_loader_if.sv
// Stream-in / block-write bundle between a program host and the core instruction loader.
// The master modport is the host side; the slave modport is the loader.
interface core_ins_loader_if #(
  parameter int INSTRUCTION_WIDTH   = 64,
  parameter int INS_INTERCORE_DEPTH = 4096
);
  logic                           start;
  logic [15:0]                    base_block;
  logic [16:0]                    num_ins;
  logic                           in_valid;
  logic [INSTRUCTION_WIDTH-1:0]   in_data;
  logic                           in_ready;
  logic                           web;
  logic [15:0]                    c_i_m_write_addr;
  logic [INS_INTERCORE_DEPTH-1:0] core_ins_input;
  logic                           busy;
  logic                           done;
  logic                           err;

  modport master (
    output start, base_block, num_ins, in_valid, in_data,
    input  in_ready, web, c_i_m_write_addr, core_ins_input, busy, done, err
  );

  modport slave (
    input  start, base_block, num_ins, in_valid, in_data,
    output in_ready, web, c_i_m_write_addr, core_ins_input, busy, done, err
  );
endinterface

// File: rtl/core_ins_loader.sv
// Packs a valid/ready stream of instructions into 64-slot blocks and issues one-cycle
// block writes to the core instruction memory, zero-padding a trailing partial block.
module core_ins_loader #(
  parameter int INSTRUCTION_WIDTH   = 64,
  parameter int INS_PER_BLOCK       = 64,
  parameter int INS_INTERCORE_DEPTH = 4096,
  parameter int NUM_BLOCKS          = 1024
) (
  input  logic              clk,
  input  logic              RSTn,
  core_ins_loader_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FILL  = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [22:0] L_CAPACITY = 23'(NUM_BLOCKS * INS_PER_BLOCK);

  state_t                         r_state;
  state_t                         w_state_nxt;
  logic [5:0]                     r_idx;
  logic [16:0]                    r_rem;
  logic [15:0]                    r_ptr;
  logic [INS_INTERCORE_DEPTH-1:0] r_buf;
  logic [INS_INTERCORE_DEPTH-1:0] w_buf_nxt;
  logic [INS_INTERCORE_DEPTH-1:0] r_blk;
  logic [15:0]                    r_addr;
  logic                           r_web;
  logic                           r_busy;
  logic                           r_err;
  logic                           r_zero;

  logic        w_fire;
  logic        w_last;
  logic [22:0] w_end;
  logic        w_reject;
  logic        w_accept;
  logic        w_rej_start;

  assign w_fire      = (r_state == S_FILL) && bus.in_valid;
  assign w_last      = w_fire && ((r_idx == 6'd63) || (r_rem == 17'd1));
  assign w_end       = {1'b0, bus.base_block, 6'b0} + {6'b0, bus.num_ins};
  assign w_reject    = (w_end > L_CAPACITY);
  assign w_accept    = (r_state == S_IDLE) && bus.start && !w_reject;
  assign w_rej_start = (r_state == S_IDLE) && bus.start && w_reject;

  // Pack buffer with the current beat merged into its slot.
  always_comb begin
    w_buf_nxt = r_buf;
    if (w_fire) begin
      w_buf_nxt[r_idx*INSTRUCTION_WIDTH +: INSTRUCTION_WIDTH] = bus.in_data;
    end else begin
      w_buf_nxt = r_buf;
    end
  end

  // Next-state decode.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_state_nxt = (bus.num_ins == 17'd0) ? S_DONE : S_FILL;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_FILL: begin
        if (w_last) begin
          w_state_nxt = S_WRITE;
        end else begin
          w_state_nxt = S_FILL;
        end
      end
      S_WRITE: begin
        if (r_rem == 17'd0) begin
          w_state_nxt = S_DONE;
        end else begin
          w_state_nxt = S_FILL;
        end
      end
      // An empty load lingers one extra DONE cycle so its done pulse lands two cycles after start.
      S_DONE: begin
        if (r_zero) begin
          w_state_nxt = S_DONE;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Datapath: pointer, count, pack buffer and registered write outputs.
  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) begin
      r_idx  <= 6'd0;
      r_rem  <= 17'd0;
      r_ptr  <= 16'd0;
      r_buf  <= '0;
      r_blk  <= '0;
      r_addr <= 16'd0;
      r_web  <= 1'b0;
      r_busy <= 1'b0;
      r_err  <= 1'b0;
      r_zero <= 1'b0;
    end else begin
      r_err <= w_rej_start;
      r_web <= w_last;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_ptr  <= bus.base_block;
            r_rem  <= bus.num_ins;
            r_buf  <= '0;
            r_idx  <= 6'd0;
            r_busy <= 1'b1;
            r_zero <= (bus.num_ins == 17'd0);
          end
        end
        S_FILL: begin
          if (w_fire) begin
            r_buf <= w_buf_nxt;
            r_idx <= r_idx + 6'd1;
            if (r_rem != 17'd0) begin
              r_rem <= r_rem - 17'd1;
            end
            if (w_last) begin
              r_blk  <= w_buf_nxt;
              r_addr <= r_ptr;
            end
          end
        end
        S_WRITE: begin
          r_ptr <= r_ptr + 16'd1;
          r_buf <= '0;
          r_idx <= 6'd0;
        end
        S_DONE: begin
          if (r_zero) begin
            r_zero <= 1'b0;
          end else begin
            r_busy <= 1'b0;
          end
        end
        default: begin
          r_busy <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready         = (r_state == S_FILL);
  assign bus.web              = r_web;
  assign bus.c_i_m_write_addr = r_addr;
  assign bus.core_ins_input   = r_blk;
  assign bus.busy             = r_busy;
  assign bus.done             = (r_state == S_DONE) && !r_zero;
  assign bus.err              = r_err;

endmodule

// File: tb/tb_core_ins_loader.sv
// Bench for core_ins_loader: table of load commands with a block scoreboard, plus
// hand-written sequences for empty load, rejected start and mid-load reset.
module tb_core_ins_loader;

  logic clk = 1'b0;
  logic RSTn;
  always #5 clk = ~clk;

  core_ins_loader_if #(.INSTRUCTION_WIDTH(64), .INS_INTERCORE_DEPTH(4096)) bus ();

  core_ins_loader dut (
    .clk  (clk),
    .RSTn (RSTn),
    .bus  (bus.slave)
  );

  typedef struct {
    logic [15:0]   addr;
    logic [4095:0] data;
  } blk_t;

  typedef struct {
    int base;
    int num;
    bit gaps;
    int poke;
    int tag;
    int exp_webs;
  } vec_t;

  blk_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   n_web = 0;
  logic prev_web = 1'b0;

  function automatic logic [63:0] beat(input int tag, input int k);
    logic [31:0] lo;
    lo = 32'(k) * 32'h9E37_79B1 + 32'h0000_0001;
    return {16'hBEEF, 16'(tag), lo};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Watches the memory write port every cycle and scores each block against the queue.
  task automatic mon();
    blk_t e;
    int   bad;
    if (bus.web) begin
      n_web++;
      chk("in_ready_in_write", 64'(bus.in_ready), 64'd0);
      chk("web_consecutive", 64'(prev_web), 64'd0);
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_web: got write at addr %0d expected none", bus.c_i_m_write_addr);
      end else begin
        e = exp_q.pop_front();
        chk("write_addr", 64'(bus.c_i_m_write_addr), 64'(e.addr));
        bad = -1;
        for (int s = 0; s < 64; s++) begin
          if (bad < 0 && bus.core_ins_input[s*64 +: 64] !== e.data[s*64 +: 64]) bad = s;
        end
        n_cmp++;
        if (bad >= 0) begin
          n_bad++;
          $display("FAIL block_data addr %0d slot %0d: got %0h expected %0h", e.addr, bad,
                   bus.core_ins_input[bad*64 +: 64], e.data[bad*64 +: 64]);
        end
      end
    end
    prev_web = bus.web;
  endtask

  task automatic tick();
    @(negedge clk);
    mon();
  endtask

  task automatic run_load(input vec_t v);
    logic [4095:0] blk;
    int  sent;
    int  cyc;
    int  webs0;
    int  slot;
    bit  val;
    bit  poked;
    bit  just_poked;
    blk        = '0;
    sent       = 0;
    cyc        = 0;
    poked      = 1'b0;
    webs0      = n_web;
    bus.base_block = 16'(v.base);
    bus.num_ins    = 17'(v.num);
    bus.start      = 1'b1;
    tick();
    bus.start = 1'b0;
    chk("busy_after_start", 64'(bus.busy), 64'd1);
    chk("ready_after_start", 64'(bus.in_ready), 64'd1);
    while (sent < v.num && cyc < v.num * 4 + 200) begin
      bus.start  = 1'b0;
      just_poked = 1'b0;
      if (v.poke == sent && !poked) begin
        bus.start      = 1'b1;
        bus.base_block = 16'd0;
        bus.num_ins    = 17'd5;
        poked          = 1'b1;
        just_poked     = 1'b1;
      end
      val          = v.gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      bus.in_valid = val;
      bus.in_data  = beat(v.tag, sent);
      if (val && bus.in_ready) begin
        slot = sent % 64;
        blk[slot*64 +: 64] = beat(v.tag, sent);
        if (slot == 63 || sent == v.num - 1) begin
          exp_q.push_back('{addr: 16'(v.base + sent / 64), data: blk});
          blk = '0;
        end
        sent++;
      end
      tick();
      cyc++;
      if (just_poked) begin
        bus.start = 1'b0;
        chk("err_on_busy_start", 64'(bus.err), 64'd0);
      end
    end
    if (sent < v.num) begin
      n_cmp++;
      n_bad++;
      $display("FAIL load_timeout: got %0d beats accepted expected %0d", sent, v.num);
    end
    bus.in_valid = 1'b0;
    bus.start    = 1'b0;
    chk("web_after_last", 64'(bus.web), 64'd1);
    tick();
    chk("done_pulse", 64'(bus.done), 64'd1);
    chk("busy_in_done", 64'(bus.busy), 64'd1);
    tick();
    chk("busy_dropped", 64'(bus.busy), 64'd0);
    chk("done_cleared", 64'(bus.done), 64'd0);
    chk("web_count", 64'(n_web - webs0), 64'(v.exp_webs));
    chk("queue_empty", 64'(exp_q.size()), 64'd0);
    exp_q.delete();
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_in_ready"}, 64'(bus.in_ready), 64'd0);
    chk({tag, "_web"}, 64'(bus.web), 64'd0);
    chk({tag, "_addr"}, 64'(bus.c_i_m_write_addr), 64'd0);
    chk({tag, "_data_nonzero"}, 64'(|bus.core_ins_input), 64'd0);
    chk({tag, "_busy"}, 64'(bus.busy), 64'd0);
    chk({tag, "_done"}, 64'(bus.done), 64'd0);
    chk({tag, "_err"}, 64'(bus.err), 64'd0);
  endtask

  vec_t vt[7];
  int   webs0;

  initial begin
    vt[0] = '{base: 0,    num: 64,   gaps: 1'b0, poke: -1, tag: 1, exp_webs: 1};
    vt[1] = '{base: 2,    num: 70,   gaps: 1'b0, poke: -1, tag: 2, exp_webs: 2};
    vt[2] = '{base: 10,   num: 130,  gaps: 1'b0, poke: -1, tag: 3, exp_webs: 3};
    vt[3] = '{base: 10,   num: 130,  gaps: 1'b1, poke: -1, tag: 3, exp_webs: 3};
    vt[4] = '{base: 7,    num: 64,   gaps: 1'b0, poke: 10, tag: 4, exp_webs: 1};
    vt[5] = '{base: 1000, num: 1536, gaps: 1'b0, poke: -1, tag: 5, exp_webs: 24};
    vt[6] = '{base: 1023, num: 64,   gaps: 1'b1, poke: -1, tag: 6, exp_webs: 1};

    RSTn           = 1'b0;
    bus.start      = 1'b0;
    bus.base_block = 16'd0;
    bus.num_ins    = 17'd0;
    bus.in_valid   = 1'b0;
    bus.in_data    = 64'd0;
    #1;
    chk_all_zero("reset");
    tick();
    tick();
    RSTn = 1'b1;
    tick();

    for (int i = 0; i < 7; i++) begin
      run_load(vt[i]);
    end
    chk("addr_holds", 64'(bus.c_i_m_write_addr), 64'd1023);

    // Empty load: busy for two cycles, done in the second, no write.
    webs0          = n_web;
    bus.base_block = 16'd4;
    bus.num_ins    = 17'd0;
    bus.start      = 1'b1;
    tick();
    bus.start = 1'b0;
    chk("zero_busy1", 64'(bus.busy), 64'd1);
    chk("zero_done1", 64'(bus.done), 64'd0);
    chk("zero_ready", 64'(bus.in_ready), 64'd0);
    tick();
    chk("zero_busy2", 64'(bus.busy), 64'd1);
    chk("zero_done2", 64'(bus.done), 64'd1);
    tick();
    chk("zero_busy3", 64'(bus.busy), 64'd0);
    chk("zero_done3", 64'(bus.done), 64'd0);
    chk("zero_no_web", 64'(n_web - webs0), 64'd0);

    // Rejected start: one past the end of memory.
    bus.base_block = 16'd1023;
    bus.num_ins    = 17'd65;
    bus.start      = 1'b1;
    tick();
    bus.start = 1'b0;
    chk("rej_err", 64'(bus.err), 64'd1);
    chk("rej_busy", 64'(bus.busy), 64'd0);
    chk("rej_ready", 64'(bus.in_ready), 64'd0);
    tick();
    chk("rej_err_clear", 64'(bus.err), 64'd0);
    chk("rej_busy2", 64'(bus.busy), 64'd0);
    chk("rej_no_web", 64'(n_web - webs0), 64'd0);

    // Reset after 30 beats of a 64-beat load, then a clean load at base 5.
    bus.base_block = 16'd0;
    bus.num_ins    = 17'd64;
    bus.start      = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int k = 0; k < 30; k++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = beat(7, k);
      tick();
    end
    bus.in_valid = 1'b0;
    #2;
    RSTn = 1'b0;
    #1;
    chk_all_zero("abort");
    tick();
    tick();
    RSTn = 1'b1;
    tick();
    chk("abort_no_web", 64'(n_web - webs0), 64'd0);
    run_load('{base: 5, num: 64, gaps: 1'b0, poke: -1, tag: 8, exp_webs: 1});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
